// File: rtl/wb_cmd_initiator.sv
// Wishbone classic single-transfer master: turns one command into one bus
// read or write and reports the result (data or timeout) on a response stream.
module wb_cmd_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TXN_CNT_W      = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,

  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [31:0]          cmd_adr,
  input  logic [31:0]          cmd_dat,
  input  logic [3:0]           cmd_sel,

  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_dat,
  output logic                 rsp_err,

  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic                 wbm_ack_i,
  input  logic [31:0]          wbm_dat_i,

  output logic [TXN_CNT_W-1:0] txn_count,
  output logic [7:0]           timeout_count
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                 state_q,     state_d;
  logic                   cyc_q,       cyc_d;
  logic                   we_q,        we_d;
  logic [3:0]             sel_q,       sel_d;
  logic [31:0]            adr_q,       adr_d;
  logic [31:0]            dat_q,       dat_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rsp_dat_q,   rsp_dat_d;
  logic                   rsp_err_q,   rsp_err_d;
  logic [TXN_CNT_W-1:0]   txn_cnt_q,   txn_cnt_d;
  logic [7:0]             to_cnt_q,    to_cnt_d;
  logic [15:0]            tmr_q,       tmr_d;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      txn_cnt_q   <= '0;
      to_cnt_q    <= '0;
      tmr_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      txn_cnt_q   <= txn_cnt_d;
      to_cnt_q    <= to_cnt_d;
      tmr_q       <= tmr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    txn_cnt_d   = txn_cnt_q;
    to_cnt_d    = to_cnt_q;
    tmr_d       = tmr_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cyc_d   = 1'b1;
          tmr_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack is tested first so an ack on the expiry edge completes normally.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          txn_cnt_d   = txn_cnt_q + TXN_CNT_W'(1);
          state_d     = RESP;
        end else if (tmr_q == TMR_LAST) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          if (to_cnt_q != '1) begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
          state_d     = RESP;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_dat       = rsp_dat_q;
  assign rsp_err       = rsp_err_q;
  assign wbm_cyc_o     = cyc_q;
  assign wbm_stb_o     = cyc_q;
  assign wbm_we_o      = we_q;
  assign wbm_sel_o     = sel_q;
  assign wbm_adr_o     = adr_q;
  assign wbm_dat_o     = dat_q;
  assign txn_count     = txn_cnt_q;
  assign timeout_count = to_cnt_q;

endmodule

// File: doc/wb_cmd_initiator.md
Name: wb_cmd_initiator

Overview:
- Wishbone classic single-transfer bus master that drives the ReRAM Wishbone slave interface from a simple command/response stream.
- Intended sources of the command stream are a logic-analyzer bridge or an on-chip test sequencer.
- Converts one command into one Wishbone read or write.
- Returns read data or a timeout error on the response stream, and keeps transaction and timeout statistics.

Parameters:
- TIMEOUT_CYCLES, 64: bus cycles to wait for wbm_ack_i before aborting. Range 2..65535.
- TXN_CNT_W, 16: width of the completed-transaction counter.

Ports:
- wb_clk_i  input  1  single clock; all logic is on the rising edge.
- wb_rst_i  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_adr  input  32  byte address.
- cmd_dat  input  32  write data.
- cmd_sel  input  4  byte selects.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_dat  output  32  read data; 0 for writes and for timeouts.
- rsp_err  output  1  1 = transfer timed out.
- wbm_cyc_o  output  1  Wishbone cycle.
- wbm_stb_o  output  1  Wishbone strobe.
- wbm_we_o  output  1  Wishbone write enable.
- wbm_sel_o  output  4  Wishbone byte selects.
- wbm_adr_o  output  32  Wishbone address.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_ack_i  input  1  Wishbone acknowledge.
- wbm_dat_i  input  32  Wishbone read data.
- txn_count  output  TXN_CNT_W  count of acked transfers; wraps.
- timeout_count  output  8  count of timed-out transfers; saturates at 255.

Behaviour:
- Reset:
  - Reset is synchronous and active-high on wb_rst_i, sampled on the rising edge of wb_clk_i.
  - It forces state IDLE and clears every register.
  - Reset values: cmd_ready=1 once in IDLE; rsp_valid=0, rsp_dat=0, rsp_err=0; wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_sel_o=0, wbm_adr_o=0, wbm_dat_o=0; txn_count=0, timeout_count=0.
- All outputs are registered except cmd_ready, which decodes as (state==IDLE).
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - A command is accepted when cmd_valid & cmd_ready.
  - On that edge: latch we/adr/dat/sel into the wbm_* outputs, set cyc=stb=1, clear the timeout counter, and go to BUS.
  - The Wishbone request is therefore visible the cycle after acceptance.
- BUS:
  - cyc, stb, we, sel, adr and dat are held stable.
  - On the edge where wbm_ack_i=1:
    - drop cyc/stb;
    - load rsp_dat with wbm_dat_i for a read, or 0 for a write;
    - set rsp_err=0 and rsp_valid=1;
    - increment txn_count (modulo 2^TXN_CNT_W);
    - go to RESP.
  - Otherwise the timeout counter increments.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack, the next edge:
    - drops cyc/stb;
    - sets rsp_dat=0, rsp_err=1 and rsp_valid=1;
    - increments timeout_count (saturating at 255);
    - goes to RESP.
  - An ack arriving on the same edge as the timeout expiry wins: it completes as success.
- RESP:
  - rsp_valid and the response payload are held until rsp_ready=1.
  - On the rsp_valid & rsp_ready edge: clear rsp_valid and go to IDLE.
  - cmd_ready rises the following cycle. No command is accepted in the handshake cycle itself.
- Latency, with command accepted at edge N and ack sampled at edge N+k (k≥1):
  - cyc/stb are high during cycles N+1..N+k.
  - rsp_valid is high from N+k+1.
  - A zero-wait-state slave gives 2 cycles from command accept to response.
- Spurious ack: wbm_ack_i while not in BUS is ignored. No counter changes and no state changes.
- Outstanding transfers: exactly one at a time; no pipelining and no bursts. wbm_cyc_o always equals wbm_stb_o.
- Reset mid-operation: cyc/stb and rsp_valid drop on the reset edge. The in-flight transfer produces no response. Counters clear.
- Hold cmd_* changes while not in IDLE have no effect.

Test Plan:
- Write, zero-wait:
  - Stimulus: cmd_we=1, adr=0x3000_0004, dat=0xA5A5_1234, sel=0xF; slave acks on the first stb cycle.
  - Response: wbm_* carry exactly those values for 1 cycle; rsp_valid 2 cycles after accept with rsp_dat=0, rsp_err=0; txn_count=1.
- Read with 3 wait states:
  - Stimulus: slave returns wbm_dat_i=0xDEAD_BEEF with the ack on the 4th stb cycle.
  - Response: cyc/stb high for exactly 4 cycles; rsp_dat=0xDEAD_BEEF, rsp_err=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8, slave never acks.
  - Response: cyc/stb high for 8 cycles then low; rsp_err=1, rsp_dat=0; timeout_count=1; txn_count unchanged.
- Backpressure and spurious ack:
  - Stimulus: hold rsp_ready=0 for 5 cycles after the response; pulse wbm_ack_i during RESP; keep cmd_valid=1.
  - Response: response stays stable; cmd_ready=0; no counter change; a new command is accepted only the cycle after the rsp handshake.
- Reset mid-transfer:
  - Stimulus: assert wb_rst_i for 1 cycle while in BUS.
  - Response: cyc/stb=0 and all counters=0 on the next edge; no rsp_valid; cmd_ready=1.
- Ack coincident with timeout expiry, plus wrap:
  - Stimulus: ack coincident with timeout expiry; then preload txn_count to 0xFFFF and complete one transfer.
  - Response: first transfer completes as success (rsp_err=0); txn_count wraps to 0x0000.
